lock_code_sequencer: RTL and testbench
======================================

# lock_code_sequencer

Drives the combination-lock inputs (sw1, sw2, sw8 and the active-low pushbutton) from a programmed list of switch codes. It is the initiating side of the lock's button/switch interface. For each entry it sets the switch levels, waits a setup time, holds the button low past the lock's 500 000-cycle debounce, then releases it. It sits beside the lock on the board and is used for self-test and auto-unlock.

## Interface
Parameters:
- MAX_STEPS, 8, depth of the code list (power of two, ≥2)
- SETUP_CYCLES, 1000, switch-stable cycles before the button is pressed (≥1)
- PRESS_CYCLES, 600000, button-low cycles (must exceed the lock debounce delay of 500000)
- GAP_CYCLES, 600000, button-high cycles after release, switches still held (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  write one code-list entry
- wr_addr  in  $clog2(MAX_STEPS)  entry index
- wr_data  in  3  code {sw1,sw2,sw8}
- code_len  in  $clog2(MAX_STEPS)+1  number of entries to play, 0..MAX_STEPS
- start  in  1  single-cycle start request
- sw1, sw2, sw8  out  1 each  switch levels to the lock
- btn_n  out  1  pushbutton to the lock, low = pressed
- busy  out  1  high from the cycle after an accepted start through the last GAP
- done  out  1  single-cycle pulse at sequence end
- step_idx  out  $clog2(MAX_STEPS)  entry currently being played

## Operation
- FSM states: IDLE, SETUP, PRESS, GAP, FINISH.
- IDLE:
  - start with code_len>0 → SETUP; step_idx=0; switches take entry 0.
  - start with code_len=0 → FINISH; no press is issued.
- code_len is sampled when start is accepted. Later changes have no effect on the run in progress. Values above MAX_STEPS are clamped to MAX_STEPS.
- SETUP lasts SETUP_CYCLES, btn_n=1 → PRESS.
- PRESS lasts PRESS_CYCLES, btn_n=0 → GAP.
- GAP lasts GAP_CYCLES, btn_n=1, switches unchanged. At the end of GAP:
  - if step_idx = len−1 → FINISH;
  - otherwise step_idx+1, switches load the next entry, → SETUP.
- FINISH lasts one cycle: done=1, busy=0 → IDLE. Switches keep the last code until the next start.
- Switch outputs change only on SETUP entry, never during PRESS or GAP.
- Code list writes are accepted only when busy=0. Writes while busy are dropped. A write and a start in the same cycle: the write lands first and the run uses the new value.
- start while busy is ignored.
- A single down-counter times all states. It loads (duration−1) on state entry, and the state advances when the count reaches 0.

## Timing
- Reset (asynchronous assert, release synchronous to clk) sets:
  - state=IDLE, sw1=sw2=sw8=0, btn_n=1, busy=0, done=0, step_idx=0;
  - all code entries = 3'b000.
- All outputs are registered.
- start accepted at edge N:
  - busy=1 and switches valid after edge N+1;
  - btn_n falls after edge N+1+SETUP_CYCLES.
- Per-step period = SETUP_CYCLES+PRESS_CYCLES+GAP_CYCLES cycles.
- done is high for exactly one cycle, starting the cycle after the last GAP ends. busy falls in that same cycle.
- A new start is accepted in the cycle after done.
- Reset mid-run releases the button immediately (btn_n=1) and discards the rest of the run.

## Configuration
- LOCK_SEQ_ABORT_EN defined:
  - adds input abort (1 bit).
  - abort while busy → the next cycle has btn_n=1 and the FSM goes to FINISH. done pulses and step_idx holds the aborted entry.
  - abort beats start in the same cycle.
  - abort is ignored in IDLE.
- LOCK_SEQ_ABORT_EN undefined: no abort port; a sequence always completes.

## Structure
- Shared package lock_pkg:
  - state enum;
  - code typedef (logic [2:0], bit order {sw1,sw2,sw8});
  - named codes CODE_ARM=3'b001, CODE_ZERO=3'b000, CODE_BOTH=3'b110, CODE_ALL=3'b111;
  - default timing constants.
- Sub-module lock_seq_timer: loadable down-counter, width $clog2(max duration)+1, outputs expired.

## Test plan
All scenarios run with SETUP=2, PRESS=5, GAP=3.
- Reset → sw=000, btn_n=1, busy=0, done=0. Assert reset during PRESS → btn_n=1 within 0 cycles of assertion; busy=0.
- Load {001,000,000}, len=3, start → three btn_n low pulses, each 5 cycles. Switches read 001, 000, 000 during each press. done pulses 30 cycles after the first busy cycle.
- len=0, start → done the cycle after start; btn_n never low.
- Start during a run → ignored. Write to entry 0 during a run → entry 0 unchanged after the run (readback by replay).
- Timing check: btn_n low exactly 5 cycles. Switch change to btn_n fall = 2 cycles. btn_n rise to next switch change = 3 cycles.
- LOCK_SEQ_ABORT_EN: abort during the 2nd PRESS → btn_n=1 the next cycle, done pulse, step_idx=1.

Source files
------------

// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared state enum, switch-code type, named codes and default timing for the lock code sequencer
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PRESS,
        GAP,
        FINISH
    } lock_state_e;

    // Bit order {sw1, sw2, sw8}
    typedef logic [2:0] lock_code_t;

    localparam lock_code_t CODE_ZERO = 3'b000;
    localparam lock_code_t CODE_ARM  = 3'b001;
    localparam lock_code_t CODE_BOTH = 3'b110;
    localparam lock_code_t CODE_ALL  = 3'b111;

    localparam int DEF_MAX_STEPS    = 8;
    localparam int DEF_SETUP_CYCLES = 1000;
    localparam int DEF_PRESS_CYCLES = 600000;  // comfortably past the lock's 500000-cycle debounce
    localparam int DEF_GAP_CYCLES   = 600000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_code_sequencer_if.sv
// rtl/lock_code_sequencer_if.sv - host code-list/start signals and lock switch/button outputs; abort only with LOCK_SEQ_ABORT_EN
interface lock_code_sequencer_if #(
    parameter int MAX_STEPS = 8
);
    import lock_pkg::*;

    localparam int SW = $clog2(MAX_STEPS);

    logic          wr_en;
    logic [SW-1:0] wr_addr;
    lock_code_t    wr_data;
    logic [SW:0]   code_len;
    logic          start;
`ifdef LOCK_SEQ_ABORT_EN
    logic          abort;
`endif
    logic          sw1;
    logic          sw2;
    logic          sw8;
    logic          btn_n;
    logic          busy;
    logic          done;
    logic [SW-1:0] step_idx;

`ifdef LOCK_SEQ_ABORT_EN
    modport master (
        input  wr_en, wr_addr, wr_data, code_len, start, abort,
        output sw1, sw2, sw8, btn_n, busy, done, step_idx
    );
    modport slave (
        output wr_en, wr_addr, wr_data, code_len, start, abort,
        input  sw1, sw2, sw8, btn_n, busy, done, step_idx
    );
`else
    modport master (
        input  wr_en, wr_addr, wr_data, code_len, start,
        output sw1, sw2, sw8, btn_n, busy, done, step_idx
    );
    modport slave (
        output wr_en, wr_addr, wr_data, code_len, start,
        input  sw1, sw2, sw8, btn_n, busy, done, step_idx
    );
`endif

endinterface

// File: rtl/lock_seq_timer.sv
// rtl/lock_seq_timer.sv - loadable down-counter that flags expiry when it reaches zero
module lock_seq_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Reload on state entry, otherwise count down and rest at zero
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/lock_code_sequencer.sv
// rtl/lock_code_sequencer.sv - plays a stored switch-code list into the lock as setup/press/gap button cycles; LOCK_SEQ_ABORT_EN adds abort
module lock_code_sequencer
    import lock_pkg::*;
#(
    parameter int MAX_STEPS    = DEF_MAX_STEPS,
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int PRESS_CYCLES = DEF_PRESS_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    lock_code_sequencer_if.master bus
);

    localparam int SW = $clog2(MAX_STEPS);
    localparam int LW = SW + 1;
    localparam int TW = $clog2(max3(SETUP_CYCLES, PRESS_CYCLES, GAP_CYCLES)) + 1;

    localparam logic [TW-1:0] SETUP_LOAD = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] PRESS_LOAD = TW'(PRESS_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
    localparam logic [LW-1:0] LEN_MAX    = LW'(MAX_STEPS);

    lock_state_e   state_q, state_d;
    lock_code_t    mem_q [MAX_STEPS];
    lock_code_t    mem_d [MAX_STEPS];
    logic [LW-1:0] len_q, len_d;
    logic [SW-1:0] step_q, step_d;
    lock_code_t    sw_q, sw_d;
    logic          btn_n_q, btn_n_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_expired;
    logic [LW-1:0] start_len;
    logic [SW-1:0] next_step;
    logic          is_last;

    lock_seq_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // Next-state, code-list write and registered-output decisions
    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        len_d    = len_q;
        step_d   = step_q;
        sw_d     = sw_q;
        btn_n_d  = btn_n_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;

        start_len = (bus.code_len > LEN_MAX) ? LEN_MAX : bus.code_len;
        next_step = step_q + SW'(1);
        is_last   = ({1'b0, step_q} == (len_q - LW'(1)));

        // The list is frozen while a run is playing; a write alongside start lands first
        if (bus.wr_en && !busy_q) begin
            mem_d[bus.wr_addr] = bus.wr_data;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (start_len == '0) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = SETUP;
                        len_d    = start_len;
                        step_d   = '0;
                        sw_d     = mem_d[0];
                        busy_d   = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = SETUP_LOAD;
                    end
                end
            end
            SETUP: begin
                if (tmr_expired) begin
                    state_d  = PRESS;
                    btn_n_d  = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = PRESS_LOAD;
                end
            end
            PRESS: begin
                if (tmr_expired) begin
                    state_d  = GAP;
                    btn_n_d  = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end
            end
            GAP: begin
                if (tmr_expired) begin
                    if (is_last) begin
                        state_d = FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = SETUP;
                        step_d   = next_step;
                        sw_d     = mem_q[next_step];
                        tmr_load = 1'b1;
                        tmr_val  = SETUP_LOAD;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef LOCK_SEQ_ABORT_EN
        // Abort releases the button at once and ends the run on the current entry
        if (bus.abort && busy_q) begin
            state_d  = FINISH;
            btn_n_d  = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            step_d   = step_q;
            sw_d     = sw_q;
            tmr_load = 1'b0;
        end
`endif
    end

    // FSM state, code list and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            for (int i = 0; i < MAX_STEPS; i++) begin
                mem_q[i] <= CODE_ZERO;
            end
            len_q   <= '0;
            step_q  <= '0;
            sw_q    <= CODE_ZERO;
            btn_n_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            len_q   <= len_d;
            step_q  <= step_d;
            sw_q    <= sw_d;
            btn_n_q <= btn_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.sw1      = sw_q[2];
    assign bus.sw2      = sw_q[1];
    assign bus.sw8      = sw_q[0];
    assign bus.btn_n    = btn_n_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.step_idx = step_q;

endmodule

// File: tb/tb_lock_code_sequencer.sv
// tb/tb_lock_code_sequencer.sv - directed and randomized bench with a schedule-based reference model; covers LOCK_SEQ_ABORT_EN when defined
module tb_lock_code_sequencer;
    import lock_pkg::*;

    localparam int MAX_STEPS = 8;
    localparam int SETUP     = 2;
    localparam int PRESS     = 5;
    localparam int GAP       = 3;
    localparam int PERIOD    = SETUP + PRESS + GAP;
    localparam int SW        = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lock_code_sequencer_if #(.MAX_STEPS(MAX_STEPS)) bus ();

    lock_code_sequencer #(
        .MAX_STEPS    (MAX_STEPS),
        .SETUP_CYCLES (SETUP),
        .PRESS_CYCLES (PRESS),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a run is expanded into its full per-cycle output schedule at start
    typedef struct packed {
        logic [2:0]    sw;
        logic          btn_n;
        logic          busy;
        logic          done;
        logic [SW-1:0] step;
    } obs_t;

    obs_t       cur;
    obs_t       sched[$];
    lock_code_t mem [MAX_STEPS];

    function automatic obs_t mk(input logic [2:0] s, input logic b, input logic bz,
                                input logic d, input logic [SW-1:0] st);
        obs_t o;
        o.sw = s; o.btn_n = b; o.busy = bz; o.done = d; o.step = st;
        return o;
    endfunction

    task automatic model_step();
        obs_t nxt;
        int   len;
        bit   idle;
        idle = !cur.busy && !cur.done;
        if (sched.size() > 0) nxt = sched.pop_front();
        else                  nxt = mk(cur.sw, 1'b1, 1'b0, 1'b0, cur.step);
        if (bus.wr_en && !cur.busy) mem[bus.wr_addr] = bus.wr_data;
        if (bus.start && idle) begin
            len = (int'(bus.code_len) > MAX_STEPS) ? MAX_STEPS : int'(bus.code_len);
            if (len == 0) begin
                nxt = mk(cur.sw, 1'b1, 1'b0, 1'b1, cur.step);
            end else begin
                sched.delete();
                for (int i = 0; i < len; i++)
                    for (int c = 0; c < PERIOD; c++)
                        sched.push_back(mk(mem[i], (c >= SETUP && c < SETUP + PRESS) ? 1'b0 : 1'b1,
                                           1'b1, 1'b0, SW'(i)));
                sched.push_back(mk(mem[len-1], 1'b1, 1'b0, 1'b1, SW'(len-1)));
                nxt = sched.pop_front();
            end
        end
`ifdef LOCK_SEQ_ABORT_EN
        if (bus.abort && cur.busy) begin
            sched.delete();
            nxt = mk(cur.sw, 1'b1, 1'b0, 1'b1, cur.step);
        end
`endif
        cur = nxt;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur = mk(3'b000, 1'b1, 1'b0, 1'b0, '0);
            sched.delete();
            for (int i = 0; i < MAX_STEPS; i++) mem[i] = CODE_ZERO;
        end else begin
            model_step();
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        obs_t act;
        if (reset) begin
            act = mk({bus.sw1, bus.sw2, bus.sw8}, bus.btn_n, bus.busy, bus.done, bus.step_idx);
            chk("model_outputs", 32'(act), 32'(cur));
        end
    end

    // Event recorder for the hand-computed timing expectations
    int         fall_c[$];
    int         rise_c[$];
    int         swc_c[$];
    int         busy_c[$];
    int         done_c[$];
    logic [2:0] fall_sw[$];
    logic       p_btn  = 1'b1;
    logic       p_busy = 1'b0;
    logic [2:0] p_sw   = 3'b000;

    always @(negedge clk) begin
        logic [2:0] s;
        cyc++;
        s = {bus.sw1, bus.sw2, bus.sw8};
        if (p_btn && !bus.btn_n) begin fall_c.push_back(cyc); fall_sw.push_back(s); end
        if (!p_btn && bus.btn_n) rise_c.push_back(cyc);
        if (s != p_sw) swc_c.push_back(cyc);
        if (!p_busy && bus.busy) busy_c.push_back(cyc);
        if (bus.done) done_c.push_back(cyc);
        p_btn = bus.btn_n; p_busy = bus.busy; p_sw = s;
    end

    task automatic clear_rec();
        fall_c.delete(); rise_c.delete(); swc_c.delete();
        busy_c.delete(); done_c.delete(); fall_sw.delete();
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [2:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = SW'(a); bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic go(input int len);
        bus.start = 1'b1; bus.code_len = 4'(len);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!bus.done && n < budget) begin tick(); n++; end
        chk("done_within_budget", 32'(bus.done), 32'd1);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] exp_sw [3];
        int s, n;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.code_len = '0; bus.start = 1'b0;
`ifdef LOCK_SEQ_ABORT_EN
        bus.abort = 1'b0;
`endif
        tick(3);
        chk("rst_sw",    32'({bus.sw1, bus.sw2, bus.sw8}), 32'd0);
        chk("rst_btn_n", 32'(bus.btn_n), 32'd1);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_done",  32'(bus.done), 32'd0);
        chk("rst_step",  32'(bus.step_idx), 32'd0);
        reset = 1'b1;
        tick(2);

        // Three-entry run; a later code_len change must not matter
        wr(0, CODE_ARM); wr(1, CODE_ZERO); wr(2, CODE_ZERO);
        clear_rec();
        go(3);
        bus.code_len = 4'd1;
        wait_done(200);
        exp_sw[0] = CODE_ARM; exp_sw[1] = CODE_ZERO; exp_sw[2] = CODE_ZERO;
        chk("s2_press_count", 32'(fall_c.size()), 32'd3);
        if (fall_c.size() == 3 && rise_c.size() == 3)
            for (int i = 0; i < 3; i++) begin
                chk("s2_press_len", 32'(rise_c[i] - fall_c[i]), 32'(PRESS));
                chk("s2_press_sw", 32'(fall_sw[i]), 32'(exp_sw[i]));
            end
        if (busy_c.size() > 0 && done_c.size() > 0)
            chk("s2_done_latency", 32'(done_c[0] - busy_c[0]), 32'd30);

        // Switch/button spacing, start and write ignored while busy
        wr(0, CODE_BOTH); wr(1, CODE_ALL); wr(2, CODE_ARM);
        clear_rec();
        go(3);
        tick(4);
        go(2);
        wr(0, CODE_ZERO);
        wait_done(200);
        chk("s3_press_count", 32'(fall_c.size()), 32'd3);
        chk("s3_single_done", 32'(done_c.size()), 32'd1);
        if (fall_c.size() >= 2 && rise_c.size() >= 1 && swc_c.size() >= 2) begin
            chk("s3_sw_to_fall0", 32'(fall_c[0] - swc_c[0]), 32'd2);
            chk("s3_rise_to_sw1", 32'(swc_c[1] - rise_c[0]), 32'd3);
            chk("s3_sw_to_fall1", 32'(fall_c[1] - swc_c[1]), 32'd2);
        end
        clear_rec();
        go(1);
        wait_done(100);
        if (fall_sw.size() > 0) chk("s3_entry0_kept", 32'(fall_sw[0]), 32'(CODE_BOTH));

        // Zero-length run
        clear_rec();
        s = cyc;
        go(0);
        wait_done(10);
        tick(10);
        chk("s4_no_press", 32'(fall_c.size()), 32'd0);
        chk("s4_no_busy",  32'(busy_c.size()), 32'd0);
        if (done_c.size() > 0) chk("s4_done_cycle", 32'(done_c[0]), 32'(s + 2));

        // Oversized length clamps to MAX_STEPS
        for (int i = 0; i < MAX_STEPS; i++) wr(i, 3'($urandom_range(0, 7)));
        clear_rec();
        go(15);
        wait_done(200);
        chk("s5_clamp_presses", 32'(fall_c.size()), 32'(MAX_STEPS));
        if (busy_c.size() > 0 && done_c.size() > 0)
            chk("s5_clamp_latency", 32'(done_c[0] - busy_c[0]), 32'(MAX_STEPS * PERIOD));

        // Reset during PRESS releases the button immediately
        wr(0, CODE_ALL);
        go(2);
        n = 0;
        while (bus.btn_n && n < 50) begin tick(); n++; end
        chk("s6_in_press", 32'(bus.btn_n), 32'd0);
        tick();
        #2 reset = 1'b0;
        #1;
        chk("s6_btn_released", 32'(bus.btn_n), 32'd1);
        chk("s6_busy_cleared", 32'(bus.busy), 32'd0);
        tick(2);
        reset = 1'b1;
        tick(2);

`ifdef LOCK_SEQ_ABORT_EN
        // Abort during the second press
        wr(0, CODE_ARM); wr(1, CODE_BOTH); wr(2, CODE_ALL);
        clear_rec();
        go(3);
        n = 0;
        while (fall_c.size() < 2 && n < 100) begin tick(); n++; end
        chk("s7_second_press", 32'(fall_c.size()), 32'd2);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("s7_abort_btn_n", 32'(bus.btn_n), 32'd1);
        chk("s7_abort_done",  32'(bus.done), 32'd1);
        chk("s7_abort_step",  32'(bus.step_idx), 32'd1);
        chk("s7_abort_busy",  32'(bus.busy), 32'd0);
        tick();
        chk("s7_done_single", 32'(bus.done), 32'd0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("s7_idle_abort_done", 32'(bus.done), 32'd0);
`endif

        // Randomized traffic checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            bus.wr_en    = ($urandom_range(0, 3) == 0);
            bus.wr_addr  = SW'($urandom_range(0, MAX_STEPS - 1));
            bus.wr_data  = 3'($urandom_range(0, 7));
            bus.start    = ($urandom_range(0, 15) == 0);
            bus.code_len = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15))
                                                       : 4'($urandom_range(0, 4));
`ifdef LOCK_SEQ_ABORT_EN
            bus.abort    = ($urandom_range(0, 63) == 0);
`endif
            tick();
        end
        bus.wr_en = 1'b0; bus.start = 1'b0;
`ifdef LOCK_SEQ_ABORT_EN
        bus.abort = 1'b0;
`endif
        tick(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
